load_store_unit: RTL

//  Memory-access stage between the execute stage and the word-organised data memory.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_load_align.sv | 30 +++
 rtl/load_store_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width encodings, FSM
// states and fault-decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Unsigned widths only exist for loads; 011/110/111 are never legal.
  function automatic logic is_illegal(input logic [2:0] funct3, input logic store);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return store;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword of a memory word and sign- or
// zero-extends it to a full register value.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_H:    data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_W:    data = rdata;
      F3_BU:   data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_HU:   data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one request per handshake, word-addressed memory with
// byte enables, aligned/extended load data and fault flags for bad accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_misalign,
  output logic              resp_illegal,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              store_q, store_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              misalign_q, misalign_d;
  logic              illegal_q, illegal_d;

  logic              req_ill, req_mis;
  logic [3:0]        lane_be;
  logic [XLEN-1:0]   lane_wdata;
  logic [XLEN-1:0]   load_data;

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata   (mem_rdata),
    .funct3  (funct3_q),
    .addr_lo (addr_q[1:0]),
    .data    (load_data)
  );

  // Store data is replicated across every lane the width could occupy so the
  // byte enables alone pick the written bytes.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = req_wdata;
    case (req_funct3)
      F3_B: begin
        lane_be    = 4'b0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        lane_be    = 4'b0011 << {req_addr[1], 1'b0};
        lane_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ill = is_illegal(req_funct3, req_store);
    req_mis = !req_ill && is_misaligned(req_funct3, req_addr[1:0]);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    store_d    = store_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    illegal_d  = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          funct3_d   = req_funct3;
          store_d    = req_store;
          wdata_d    = (req_store && !req_ill && !req_mis) ? lane_wdata : '0;
          be_d       = (req_store && !req_ill && !req_mis) ? lane_be : 4'b0000;
          rdata_d    = '0;
          misalign_d = req_mis;
          illegal_d  = req_ill;
          state_d    = (req_ill || req_mis) ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: state_d = store_q ? S_RESP : S_WAIT;
      S_WAIT: begin
        rdata_d = load_data;
        state_d = S_RESP;
      end
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      funct3_q   <= '0;
      store_q    <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      funct3_q   <= funct3_d;
      store_q    <= store_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      illegal_q  <= illegal_d;
    end
  end

  always_comb begin
    req_ready     = (state_q == S_IDLE);
    resp_valid    = (state_q == S_RESP);
    resp_rdata    = rdata_q;
    resp_misalign = misalign_q;
    resp_illegal  = illegal_q;
    mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
    mem_re        = (state_q == S_ACCESS) && !store_q;
    mem_we        = (state_q == S_ACCESS) && store_q;
    mem_be        = be_q;
    mem_wdata     = wdata_q;
  end

endmodule
